// File: rtl/mul8_err_sweep_ctrl_if.sv
// Bus bundle between the error-sweep controller and whoever drives it.
// The controller's side is the slave modport. The testbench or host side
// is the master modport.
// Optional macro: WORST_CASE_CAPTURE_EN adds the worst-case capture signals.
interface mul8_err_sweep_ctrl_if;
  logic        start_i;
  logic        mode_i;
  logic [7:0]  a_o;
  logic [7:0]  b_o;
  logic [15:0] approx_i;
  logic        busy_o;
  logic        done_o;
  logic [16:0] vec_cnt_o;
  logic [16:0] err_cnt_o;
  logic [31:0] sum_aed_o;
  logic [15:0] max_aed_o;
`ifdef WORST_CASE_CAPTURE_EN
  logic [7:0]  worst_a_o;
  logic [7:0]  worst_b_o;
  logic [15:0] worst_approx_o;

  modport slave (
    input  start_i, mode_i, approx_i,
    output a_o, b_o, busy_o, done_o, vec_cnt_o, err_cnt_o, sum_aed_o, max_aed_o,
           worst_a_o, worst_b_o, worst_approx_o
  );
  modport master (
    output start_i, mode_i, approx_i,
    input  a_o, b_o, busy_o, done_o, vec_cnt_o, err_cnt_o, sum_aed_o, max_aed_o,
           worst_a_o, worst_b_o, worst_approx_o
  );
`else
  modport slave (
    input  start_i, mode_i, approx_i,
    output a_o, b_o, busy_o, done_o, vec_cnt_o, err_cnt_o, sum_aed_o, max_aed_o
  );
  modport master (
    output start_i, mode_i, approx_i,
    input  a_o, b_o, busy_o, done_o, vec_cnt_o, err_cnt_o, sum_aed_o, max_aed_o
  );
`endif
endinterface

// File: rtl/mul8_err_sweep_ctrl.sv
// Error-characterisation sequencer for an 8x8 approximate multiplier.
// In exhaustive mode it walks all 65536 operand pairs. In random mode it
// walks RAND_SAMPLES LFSR vectors. For each vector it waits SETTLE_CYCLES,
// samples the multiplier result and compares it with the exact product.
// It accumulates the error count, the sum of absolute error distance and
// the maximum absolute error distance.
// Optional macro: WORST_CASE_CAPTURE_EN records the operands and the result
// of the vector with the largest error.
module mul8_err_sweep_ctrl #(
  parameter int          SETTLE_CYCLES = 4,
  parameter int          RAND_SAMPLES  = 10000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst,
  mul8_err_sweep_ctrl_if.slave bus
);

  localparam logic [7:0]  SETTLE   = 8'(SETTLE_CYCLES);
  localparam logic [16:0] RAND_CNT = 17'(RAND_SAMPLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_SAMPLE,
    ST_FIN
  } state_t;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [16:0] vec_q, vec_d;
  logic [16:0] err_q, err_d;
  logic [31:0] sum_q, sum_d;
  logic [15:0] max_q, max_d;
`ifdef WORST_CASE_CAPTURE_EN
  logic [7:0]  worst_a_q, worst_a_d;
  logic [7:0]  worst_b_q, worst_b_d;
  logic [15:0] worst_app_q, worst_app_d;
`endif

  // Datapath helpers. The exact product is taken from the registered
  // operands, so it matches what the multiplier under test is seeing.
  logic [15:0] exact;
  logic [15:0] aed;
  logic [15:0] lfsr_step;
  logic        last_vec;

  assign exact     = {8'h00, a_q} * {8'h00, b_q};
  assign aed       = (exact >= bus.approx_i) ? (exact - bus.approx_i) : (bus.approx_i - exact);
  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting towards the MSB.
  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign last_vec  = mode_q ? ((vec_q + 17'd1) == RAND_CNT) : (idx_q == 16'hFFFF);

  // Next-state and register-update logic. Every _d defaults to hold.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    vec_d   = vec_q;
    err_d   = err_q;
    sum_d   = sum_q;
    max_d   = max_q;
`ifdef WORST_CASE_CAPTURE_EN
    worst_a_d   = worst_a_q;
    worst_b_d   = worst_b_q;
    worst_app_d = worst_app_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_DRIVE;
          mode_d  = bus.mode_i;
          idx_d   = 16'h0000;
          lfsr_d  = LFSR_SEED;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          vec_d   = 17'd0;
          err_d   = 17'd0;
          sum_d   = 32'd0;
          max_d   = 16'd0;
`ifdef WORST_CASE_CAPTURE_EN
          worst_a_d   = 8'h00;
          worst_b_d   = 8'h00;
          worst_app_d = 16'h0000;
`endif
        end
      end
      ST_DRIVE: begin
        a_d     = mode_q ? lfsr_q[15:8] : idx_q[15:8];
        b_d     = mode_q ? lfsr_q[7:0]  : idx_q[7:0];
        wait_d  = SETTLE;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A count of 1 or less ends the wait. This also stops a count of
        // zero from stalling the FSM.
        if (wait_q <= 8'd1) begin
          state_d = ST_SAMPLE;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      ST_SAMPLE: begin
        vec_d = vec_q + 17'd1;
        sum_d = sum_q + {16'h0000, aed};
        if (aed != 16'h0000) begin
          err_d = err_q + 17'd1;
        end
        if (aed > max_q) begin
          max_d = aed;
`ifdef WORST_CASE_CAPTURE_EN
          worst_a_d   = a_q;
          worst_b_d   = b_q;
          worst_app_d = bus.approx_i;
`endif
        end
        if (mode_q) begin
          lfsr_d = lfsr_step;
        end else begin
          idx_d = idx_q + 16'd1;
        end
        if (last_vec) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. The reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      idx_q   <= 16'h0000;
      lfsr_q  <= LFSR_SEED;
      wait_q  <= 8'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vec_q   <= 17'd0;
      err_q   <= 17'd0;
      sum_q   <= 32'd0;
      max_q   <= 16'd0;
`ifdef WORST_CASE_CAPTURE_EN
      worst_a_q   <= 8'h00;
      worst_b_q   <= 8'h00;
      worst_app_q <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
`ifdef WORST_CASE_CAPTURE_EN
      worst_a_q   <= worst_a_d;
      worst_b_q   <= worst_b_d;
      worst_app_q <= worst_app_d;
`endif
    end
  end

  assign bus.a_o       = a_q;
  assign bus.b_o       = b_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.vec_cnt_o = vec_q;
  assign bus.err_cnt_o = err_q;
  assign bus.sum_aed_o = sum_q;
  assign bus.max_aed_o = max_q;
`ifdef WORST_CASE_CAPTURE_EN
  assign bus.worst_a_o      = worst_a_q;
  assign bus.worst_b_o      = worst_b_q;
  assign bus.worst_approx_o = worst_app_q;
`endif

endmodule

// File: doc/mul8_err_sweep_ctrl.md
Name: mul8_err_sweep_ctrl

Overview:
Sequencer that drives an 8x8 approximate multiplier under characterisation, either exhaustively or with LFSR-random operands. It waits a programmable settle time for the gate-level result, then compares it against an internal exact product. It accumulates error count, sum of absolute error distance and maximum error distance. It sits beside the approximate multiplier instance and replaces per-vector software bookkeeping with on-chip statistics.

Parameters:
SETTLE_CYCLES, 4, clock cycles between driving operands and sampling the result (legal range 1..255)
RAND_SAMPLES, 10000, number of vectors in random mode (legal range 1..65536)
LFSR_SEED, 16'hACE1, initial LFSR value in random mode (must be nonzero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  one-cycle pulse; begins a run when idle
mode_i  in  1  0 = exhaustive sweep, 1 = random; sampled on accepted start
a_o  out  8  operand A to the multiplier under test
b_o  out  8  operand B to the multiplier under test
approx_i  in  16  product returned by the multiplier under test
busy_o  out  1  high while a run is in progress
done_o  out  1  high from run completion until the next accepted start
vec_cnt_o  out  17  vectors evaluated in the current or last run
err_cnt_o  out  17  vectors where approx != exact
sum_aed_o  out  32  sum of |exact - approx|
max_aed_o  out  16  largest |exact - approx|

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs, counters, LFSR (to LFSR_SEED), index and accumulators cleared to 0.
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, FIN.
- IDLE: start_i=1 -> DRIVE. On that edge: clear all accumulators and vec_cnt, latch mode_i, index=0, LFSR=LFSR_SEED, done_o=0, busy_o=1.
- DRIVE (1 cycle): register a_o/b_o. Exhaustive: a_o=index[15:8], b_o=index[7:0]. Random: a_o=lfsr[15:8], b_o=lfsr[7:0]. -> WAIT, with wait counter loaded to SETTLE_CYCLES.
- WAIT: hold a_o/b_o for exactly SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE (1 cycle): exact = a_o*b_o (16-bit unsigned). aed = |exact - approx_i| (16-bit unsigned). Update accumulators in this cycle:
  - err_cnt += (aed != 0)
  - sum_aed += aed (32-bit, no saturation; the worst case 1,065,369,600 fits)
  - max_aed = aed if aed > max_aed (strict; ties keep the earlier value)
  - vec_cnt += 1
  - Advance: exhaustive index+1; random LFSR shifts once (Fibonacci, x^16+x^14+x^13+x^11+1).
  - Last vector (exhaustive index==65535, random vec_cnt+1==RAND_SAMPLES) -> FIN; otherwise -> DRIVE.
- Each vector costs SETTLE_CYCLES+2 cycles. An exhaustive run costs 65536*(SETTLE_CYCLES+2) cycles from the start edge to FIN.
- FIN (1 cycle): busy_o=0, done_o=1 -> IDLE. Results and a_o/b_o hold until the next accepted start or reset.
- start_i while busy_o=1 is ignored, and mode_i changes mid-run are ignored.
- approx_i is sampled only in SAMPLE; its value in any other cycle is don't-care.

Optional Feature:
WORST_CASE_CAPTURE_EN: when defined, adds outputs worst_a_o[7:0], worst_b_o[7:0] and worst_approx_o[15:0].
- They load a_o, b_o and approx_i in every SAMPLE cycle where max_aed updates (strict >).
- They are cleared on reset and on accepted start, and hold otherwise.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Exact stub (approx=a*b), mode 0, SETTLE_CYCLES=4 -> done after 393216 cycles; vec_cnt=65536, err_cnt=0, sum_aed=0, max_aed=0.
- Stub approx=(a*b)&16'hFFFE, mode 0 -> err_cnt=16384, sum_aed=16384, max_aed=1; with WORST_CASE_CAPTURE_EN, worst_a=1, worst_b=1, worst_approx=0.
- Stub approx=0, mode 0 -> err_cnt=65025, sum_aed=1065369600, max_aed=65025, vec_cnt=65536.
- Mode 1, RAND_SAMPLES=4, exact stub -> a_o/b_o sequence follows the LFSR from 16'hACE1; vec_cnt=4, err_cnt=0, done after 24 cycles.
- Assert rst during WAIT of vector 100 -> all outputs 0 on the same edge; a new start_i runs from index 0 and yields correct totals.
- start_i pulsed mid-run and mode_i toggled -> no restart; final totals match an undisturbed run; a second start after done clears the totals to 0 first.
